bcd_key_counter_fnd: RTL
========================

Name: bcd_key_counter_fnd

Overview:
- Generalised push-button BCD counter with multiplexed 7-segment (FND) output.
- Successor to the single-button, 2-digit, fixed-modulo 20 counter. Adds:
  - 2-FF synchroniser and debounce,
  - separate increment and decrement keys,
  - parametrised digit count and modulo,
  - a glitch-free scan in which DIGIT and SEG are registered together,
  - a wrap pulse.
- Sits between the board buttons and the FND pins. Used as a reusable user-input and display block.

Parameters:
- NUM_DIGITS, 4, number of BCD digits counted and scanned (1..8).
- MAX_COUNT, 9999, decimal terminal value; must be < 10**NUM_DIGITS; converted to BCD at elaboration.
- DB_CYCLES, 1000000, clk cycles a synchronised key level must hold before it is accepted (10 ms at 100 MHz).
- SCAN_DIV, 416667, clk cycles per digit slot (240 Hz step at 100 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_inc  input  1  raw increment key, active-high, asynchronous to clk
- btn_dec  input  1  raw decrement key, active-high, asynchronous to clk
- count_bcd  output  4*NUM_DIGITS  current count, digit 0 in bits [3:0]
- wrap  output  1  one-cycle pulse on a wrap-around
- SEG  output  8  segments {a,b,c,d,e,f,g,dp}, a = bit7, active-high
- DIGIT  output  NUM_DIGITS  digit enable, active-low one-hot, bit0 = ones digit

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state is cleared on the first clk edge with reset=1; reset overrides every other event.
- Reset values:
  - count_bcd = 0, wrap = 0
  - DIGIT = all ones except bit0 = 0
  - SEG = 8'hfc (digit 0 showing "0")
  - scan counter = 0, debounce counters = 0, accepted key levels = 0
- Synchroniser: each key passes through 2 flops.
- Debounce, per key:
  - Counter resets whenever the synchronised level differs from the accepted level.
  - When the counter reaches DB_CYCLES-1 with the difference still present, the accepted level takes the synchronised level.
- Edge detect: a press is a 0->1 change of the accepted level. A release produces no event.
- Latency: count_bcd changes exactly 1 clk after the accepted-level rise. Total from a raw edge = 2 + DB_CYCLES + 1 clk.
- Counting:
  - inc press only: count+1. If count == MAX_COUNT, count -> 0 and wrap=1 for 1 clk.
  - dec press only: count-1. If count == 0, count -> MAX_COUNT and wrap=1 for 1 clk.
  - inc and dec press in the same clk: count unchanged, wrap=0.
  - Holding a key yields exactly one step.
- BCD arithmetic: per-digit ripple. Increment: digit 9 -> 0 with carry. Decrement: digit 0 -> 9 with borrow. Digits never exceed 9.
- Scan:
  - A free-running counter counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances: 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
  - DIGIT and SEG are both registered from the same index in the same clk, so no cycle shows a mismatched digit and segment pattern.
- Segment map, hex 0..F: fc 60 da f2 66 b6 be e0 fe e6 ee 3e 9c 7a 9e 8e. Only 0..9 occur in normal operation. dp is always 0.
- SEG follows count changes within 1 clk while the current digit stays selected.
- Reset mid-debounce or mid-scan: the partial count is discarded, with no press event and no wrap.

Optional Feature:
- Macro: FND_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k (k > 0) shows SEG = 8'h00 when it and all higher digits are 0.
  - Digit 0 always displays.
  - DIGIT scanning is unchanged.
- Undefined: every digit shows its value, including leading zeros.

Test Plan:
- Use NUM_DIGITS=4, MAX_COUNT=0123, DB_CYCLES=4, SCAN_DIV=3 for all scenarios.
1. Reset -> count_bcd=16'h0000, DIGIT=4'b1110, SEG=8'hfc, wrap=0.
2. Raw btn_inc pulse of 2 clk -> no count change. btn_inc held high -> count=0001 exactly 7 clk after the raw rise. Held for 100 clk -> still 0001.
3. Preload to 0123 via inc presses, then one more inc -> count=0000 and wrap high for exactly 1 clk. Next dec -> count=0123 with a wrap pulse. 0009 + inc -> 0010.
4. btn_inc and btn_dec rising on the same clk -> accepted levels rise together and count stays 0042. Releasing both -> no change.
5. Scan with count=0107 -> DIGIT steps 1110, 1101, 1011, 0111 every 3 clk. SEG is 8'he0, fc, 60, fc for those slots, changing in the same clk as DIGIT. With FND_LZ_BLANK_EN and count=0007 -> digits 1..3 give SEG=8'h00 and digit 0 gives 8'he0.
6. Assert reset during debounce (count=0) and during a scan slot -> next clk matches scenario 1. Deasserting reset with the key held -> count=0001 after 2+DB_CYCLES+1 clk.

Source files
------------

// File: rtl/bcd_key_counter_fnd.sv
// Debounced inc/dec push-button BCD counter with multiplexed 7-segment scan.
// Optional leading-zero blanking: define FND_LZ_BLANK_EN.
module bcd_key_counter_fnd #(
   parameter int NUM_DIGITS = 4,
   parameter int MAX_COUNT  = 9999,
   parameter int DB_CYCLES  = 1000000,
   parameter int SCAN_DIV   = 416667
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    btn_inc,
   input  logic                    btn_dec,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    wrap,
   output logic [7:0]              SEG,
   output logic [NUM_DIGITS-1:0]   DIGIT
);
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int SCW = $clog2(SCAN_DIV + 1);
   localparam int IXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [IXW-1:0] IX_LAST = IXW'(NUM_DIGITS - 1);

   function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
      logic [4*NUM_DIGITS-1:0] b;
      int r;
      b = '0;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);

   function automatic logic [4*NUM_DIGITS-1:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] v);
      logic [4*NUM_DIGITS-1:0] r;
      logic c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [4*NUM_DIGITS-1:0] bcd_dec(input logic [4*NUM_DIGITS-1:0] v);
      logic [4*NUM_DIGITS-1:0] r;
      logic b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (b) begin
            if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_map(input logic [3:0] d);
      case (d)
         4'h0: return 8'hfc;  4'h1: return 8'h60;  4'h2: return 8'hda;  4'h3: return 8'hf2;
         4'h4: return 8'h66;  4'h5: return 8'hb6;  4'h6: return 8'hbe;  4'h7: return 8'he0;
         4'h8: return 8'hfe;  4'h9: return 8'he6;  4'ha: return 8'hee;  4'hb: return 8'h3e;
         4'hc: return 8'h9c;  4'hd: return 8'h7a;  4'he: return 8'h9e;  default: return 8'h8e;
      endcase
   endfunction

   // key index 0 = inc, 1 = dec
   logic [1:0]          s1, s2, acc, acc_d, press;
   logic [1:0][DBW-1:0] dbc;
   logic [1:0]          keys;

   assign keys = {btn_dec, btn_inc};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         acc   <= '0;
         acc_d <= '0;
         dbc   <= '0;
      end else begin
         s1    <= keys;
         s2    <= s1;
         acc_d <= acc;
         for (int k = 0; k < 2; k++) begin
            if (s2[k] == acc[k]) dbc[k] <= '0;
            else if (dbc[k] == DB_LAST) begin
               acc[k] <= s2[k];
               dbc[k] <= '0;
            end else dbc[k] <= dbc[k] + 1'b1;
         end
      end
   end

   assign press = acc & ~acc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_bcd <= '0;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (press == 2'b01) begin
            if (count_bcd == MAX_BCD) begin
               count_bcd <= '0;
               wrap      <= 1'b1;
            end else count_bcd <= bcd_inc(count_bcd);
         end else if (press == 2'b10) begin
            if (count_bcd == '0) begin
               count_bcd <= MAX_BCD;
               wrap      <= 1'b1;
            end else count_bcd <= bcd_dec(count_bcd);
         end
      end
   end

   logic [SCW-1:0] scan_cnt;
   logic [IXW-1:0] idx, nxt_idx;
   logic [3:0]     dval;
   logic           blank;

   always_comb begin
      nxt_idx = idx;
      if (scan_cnt == SC_LAST) nxt_idx = (idx == IX_LAST) ? '0 : idx + 1'b1;
      dval = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (nxt_idx == IXW'(i)) dval = count_bcd[4*i +: 4];
   end

`ifdef FND_LZ_BLANK_EN
   // walk down from the top digit so hz covers digit i and everything above it
   always_comb begin
      logic hz;
      hz    = 1'b1;
      blank = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         hz = hz & (count_bcd[4*i +: 4] == 4'd0);
         if (nxt_idx == IXW'(i)) blank = hz;
      end
   end
`else
   assign blank = 1'b0;
`endif

   // DIGIT and SEG share nxt_idx so they always change on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
         DIGIT    <= ~NUM_DIGITS'(1);
         SEG      <= 8'hfc;
      end else begin
         scan_cnt <= (scan_cnt == SC_LAST) ? '0 : scan_cnt + 1'b1;
         idx      <= nxt_idx;
         for (int i = 0; i < NUM_DIGITS; i++) DIGIT[i] <= (nxt_idx != IXW'(i));
         SEG      <= blank ? 8'h00 : seg_map(dval);
      end
   end
endmodule
